// File: rtl/pingpong_sched_pkg.sv
// Shared types and constants for the ping-pong bank scheduler.
// Bank lifecycle states and default geometry.
package pingpong_sched_pkg;
  typedef enum logic [1:0] {
    EMPTY,
    FILLING,
    FULL,
    DRAINING
  } bank_state_t;

  localparam int DEPTH_DEF = 16;
  localparam int DRAIN_CYC = DEPTH_DEF + 1;
endpackage

// File: rtl/pingpong_buf_sched_if.sv
// Producer and read-path signals of the ping-pong scheduler.
// master = producer/PE side, slave = scheduler.
interface pingpong_buf_sched_if;
  logic        wr_req;
  logic        wr_grant;
  logic        wr_bank;
  logic        wr_done;
  logic        pe_ready;
  logic        rd_sop;
  logic        rd_bank;
  logic        rd_busy;
  logic [1:0]  bank_full;
  logic        wr_err;
  logic [15:0] stall_cnt;

  modport master (
    output wr_req, wr_done, pe_ready,
    input  wr_grant, wr_bank, rd_sop, rd_bank,
    input  rd_busy, bank_full, wr_err, stall_cnt
  );

  modport slave (
    input  wr_req, wr_done, pe_ready,
    output wr_grant, wr_bank, rd_sop, rd_bank,
    output rd_busy, bank_full, wr_err, stall_cnt
  );
endinterface

// File: rtl/pingpong_bank_fsm.sv
// Lifecycle of one RAM bank:
// EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY.
module pingpong_bank_fsm
  import pingpong_sched_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        grant,
  input  logic        done,
  input  logic        start,
  input  logic        drain_end,
  output bank_state_t state
);
  bank_state_t state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      unique case (state_q)
        EMPTY:    if (grant)     state_q <= FILLING;
        FILLING:  if (done)      state_q <= FULL;
        FULL:     if (start)     state_q <= DRAINING;
        DRAINING: if (drain_end) state_q <= EMPTY;
        default:                 state_q <= EMPTY;
      endcase
    end
  end

  assign state = state_q;
endmodule

// File: rtl/pingpong_buf_sched.sv
// Ping-pong bank scheduler: write grants, read starts, drain timing.
// SCHED_STALL_CNT_EN enables the saturating wr_req stall counter.
module pingpong_buf_sched
  import pingpong_sched_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF,
  parameter int CW    = 5
) (
  input logic                 clk,
  input logic                 rst_n,
  pingpong_buf_sched_if.slave bus
);
  localparam logic [CW-1:0] DRAIN_LD = CW'(DEPTH + 1);

  bank_state_t   st [2];
  logic          wbank_q, wbank_d;
  logic          rbank_q, rbank_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          wr_act, grant, sop, drain_end;

  always_comb begin
    wr_act    = (st[0] == FILLING) || (st[1] == FILLING);
    grant     = bus.wr_req && (st[wbank_q] == EMPTY) && !wr_act;
    sop       = (st[rbank_q] == FULL) && bus.pe_ready &&
                (cnt_q == '0);
    drain_end = (cnt_q == CW'(1));
    wbank_d   = wbank_q ^ (bus.wr_done & wr_act);
    rbank_d   = rbank_q ^ drain_end;
    err_d     = err_q | (bus.wr_done & ~wr_act);
    cnt_d     = cnt_q;
    // busy spans the enable-toggle cycle plus DEPTH address cycles
    if (sop)               cnt_d = DRAIN_LD;
    else if (cnt_q != '0)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbank_q <= 1'b0;
      rbank_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      wbank_q <= wbank_d;
      rbank_q <= rbank_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    pingpong_bank_fsm u_fsm (
      .clk       (clk),
      .rst_n     (rst_n),
      .grant     (grant & (wbank_q == 1'(b))),
      .done      (bus.wr_done & (wbank_q == 1'(b))),
      .start     (sop & (rbank_q == 1'(b))),
      .drain_end (drain_end & (rbank_q == 1'(b))),
      .state     (st[b])
    );
  end

  assign bus.wr_grant  = grant;
  assign bus.wr_bank   = wbank_q;
  assign bus.rd_sop    = sop;
  assign bus.rd_bank   = rbank_q;
  assign bus.rd_busy   = (cnt_q != '0);
  assign bus.bank_full = {st[1] == FULL, st[0] == FULL};
  assign bus.wr_err    = err_q;

`ifdef SCHED_STALL_CNT_EN
  logic [15:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (bus.wr_req && !grant && (stall_q != 16'hFFFF))
      stall_d = stall_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_q <= '0;
    else        stall_q <= stall_d;
  end

  assign bus.stall_cnt = stall_q;
`else
  assign bus.stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_pingpong_buf_sched.sv
// Bench for pingpong_buf_sched: directed scenarios plus random
// producer/PE traffic against a bank-lifecycle reference model.
module tb_pingpong_buf_sched;
  localparam int D = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pingpong_buf_sched_if bus ();

  pingpong_buf_sched dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  // model: 0 empty, 1 filling, 2 full, 3 draining
  int st [2];
  int wb, rb, sop_cyc, stall;
  bit err;
  bit e_g, e_sop, e_act, e_busy;

  logic obs_g, obs_sop, obs_busy, obs_wbk, obs_err;
  logic [1:0] obs_full;
  logic [15:0] obs_stall;

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    st[0] = 0; st[1] = 0;
    wb = 0; rb = 0;
    sop_cyc = -1000;
    err = 0; stall = 0;
  endtask

  task automatic check_outs();
    int es;
    e_act  = (st[0] == 1) || (st[1] == 1);
    e_g    = rst_n && bus.wr_req && (st[wb] == 0) && !e_act;
    e_busy = (cyc_n > sop_cyc) && (cyc_n <= sop_cyc + D + 1);
    e_sop  = rst_n && (st[rb] == 2) && bus.pe_ready && !e_busy;
`ifdef SCHED_STALL_CNT_EN
    es = stall;
`else
    es = 0;
`endif
    obs_g = bus.wr_grant;   obs_sop = bus.rd_sop;
    obs_busy = bus.rd_busy; obs_wbk = bus.wr_bank;
    obs_err = bus.wr_err;   obs_full = bus.bank_full;
    obs_stall = bus.stall_cnt;
    chk("wr_grant", 16'(obs_g), 16'(e_g));
    chk("wr_bank", 16'(obs_wbk), 16'(wb));
    chk("rd_sop", 16'(obs_sop), 16'(e_sop));
    chk("rd_bank", 16'(bus.rd_bank), 16'(rb));
    chk("rd_busy", 16'(obs_busy), 16'(e_busy));
    chk("bank_full", 16'(obs_full),
        16'({st[1] == 2, st[0] == 2}));
    chk("wr_err", 16'(obs_err), 16'(err));
    chk("stall_cnt", obs_stall, 16'(es));
  endtask

  task automatic cyc(input logic rq, input logic dn, input logic rdy);
    @(negedge clk);
    bus.wr_req = rq; bus.wr_done = dn; bus.pe_ready = rdy;
    #1;
    check_outs();
    @(posedge clk);
    if (rst_n) begin
      if (e_g) st[wb] = 1;
      if (dn) begin
        if (e_act) begin st[wb] = 2; wb = 1 - wb; end
        else err = 1;
      end
      if (cyc_n == sop_cyc + D + 1) begin st[rb] = 0; rb = 1 - rb; end
      if (e_sop) begin st[rb] = 3; sop_cyc = cyc_n; end
      if (rq && !e_g && stall < 65535) stall++;
    end
    cyc_n++;
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    bus.wr_req = 0; bus.wr_done = 0; bus.pe_ready = 0;
    model_reset();
    #1;
    check_outs();
    for (int i = 0; i < n; i++) cyc(0, 0, 0);
    #2 rst_n = 1'b1;
  endtask

  task automatic fill(input logic rdy);
    int k = 0;
    do begin cyc(1, 0, rdy); k++; end while (!obs_g && k < 50);
    chk("fill_grant", 16'(obs_g), 16'd1);
    cyc(0, 0, rdy);
    cyc(0, 0, rdy);
    cyc(0, 1, rdy);
  endtask

  initial begin
    int s1, s2, gcyc, busy_n, k, gbank;
    bit got, own, want;
    logic rq, dn, rdy;

    rst_n = 1'b0;
    bus.wr_req = 0; bus.wr_done = 0; bus.pe_ready = 0;
    model_reset();
    do_reset(3);

    // reset -> immediate grant of bank 0, fill done at cycle 5
    cyc(1, 0, 0);
    chk("t1_grant", 16'(obs_g), 16'd1);
    chk("t1_bank0", 16'(obs_wbk), 16'd0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("t1_full", 16'(obs_full), 16'b01);
    cyc(1, 0, 0);
    chk("t1_grant2", 16'(obs_g), 16'd1);
    chk("t1_bank1", 16'(obs_wbk), 16'd1);
    cyc(0, 0, 0);
    cyc(0, 1, 0);

    // both full, pe_ready: sop spacing, busy length, delayed grant
    s1 = -1; s2 = -1; gcyc = -1; busy_n = 0; got = 0; gbank = -1;
    for (int i = 0; i < 40; i++) begin
      cyc(!got, 0, 1);
      if (obs_sop && s1 < 0) s1 = i;
      else if (obs_sop && s2 < 0) s2 = i;
      if (obs_busy && s2 < 0) busy_n++;
      if (obs_g && !got) begin got = 1; gcyc = i; gbank = obs_wbk; end
    end
    chk("t3_sop_first", 16'(s1), 16'd0);
    chk("t3_sop_gap", 16'(s2 - s1), 16'd18);
    chk("t3_busy_len", 16'(busy_n), 16'd17);
    chk("t3_grant_cyc", 16'(gcyc), 16'(s1 + 18));
    chk("t3_grant_bank", 16'(gbank), 16'd0);
    cyc(0, 1, 0);

    // spurious wr_done: sticky error, bank state untouched
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("t4_err", 16'(obs_err), 16'd1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("t4_err_hold", 16'(obs_err), 16'd1);

    // reset in the middle of a drain
    do_reset(2);
    fill(1);
    k = 0;
    do begin cyc(0, 0, 1); k++; end while (!obs_sop && k < 10);
    chk("t5_sop", 16'(obs_sop), 16'd1);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    do_reset(2);
    cyc(1, 0, 0);
    chk("t5_grant", 16'(obs_g), 16'd1);
    chk("t5_bank0", 16'(obs_wbk), 16'd0);

    // stall count with both banks full and PE not ready
    do_reset(2);
    fill(0);
    fill(0);
    for (int i = 0; i < 10; i++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("t6_full", 16'(obs_full), 16'b11);
`ifdef SCHED_STALL_CNT_EN
    chk("t6_stall", obs_stall, 16'd10);
`else
    chk("t6_stall", obs_stall, 16'd0);
`endif

    // random producer / PE traffic
    do_reset(2);
    own = 0; want = 0; k = 0;
    for (int i = 0; i < 1500; i++) begin
      rdy = ($urandom % 4) != 0;
      dn = 0;
      if (!own && !want) want = ($urandom % 3) == 0;
      if (own) begin
        if (k == 0) begin dn = 1; own = 0; end
        else k--;
      end else if (!want && ($urandom % 64) == 0) begin
        dn = 1;
      end
      rq = want;
      cyc(rq, dn, rdy);
      if (e_g) begin own = 1; want = 0; k = $urandom_range(0, 5); end
      if (($urandom % 400) == 0) begin
        do_reset(1);
        own = 0; want = 0;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
